rf_wb_arb: RTL
==============

Name: rf_wb_arb

Overview:
- Arbitrates the register file's single synchronous write port between two sources.
- Source 1 is the in-order pipeline writeback, which has fixed priority and is never stalled.
- Source 2 is the cache load-return path (miss refill data), which uses valid/ready and is buffered in a small FIFO.
- Exports a per-register pending-load mask for hazard detection and a starvation stall request to the pipeline.

Parameters:
- DEPTH, 2, load-return FIFO entries; power of 2, >=2.
- STARVE_MAX, 4, consecutive blocked cycles of a non-empty FIFO before a stall is requested; >=1.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wb_valid  in  1  pipeline writeback present this cycle
- i_wb_waddr  in  5  pipeline destination register
- i_wb_wdata  in  32  pipeline write data
- i_ld_valid  in  1  load-return beat valid
- o_ld_ready  out  1  FIFO can accept a beat
- i_ld_waddr  in  5  load destination register
- i_ld_wdata  in  32  load data
- o_rd_waddr  out  5  to RF write address (5'd0 = no write)
- o_rd_wdata  out  32  to RF write data
- o_ld_pending  out  32  bit r set if any FIFO entry targets xr; bit 0 always 0
- o_wb_stall  out  1  registered request: pipeline presents no writeback this cycle
- o_collision  out  1  protocol violation flag

Behaviour:
- Definitions:
  - wb_act = i_wb_valid & (i_wb_waddr != 0).
  - push = i_ld_valid & o_ld_ready.
  - pop = !empty & !wb_act.
- Output mux (combinational):
  - wb_act -> o_rd_waddr/o_rd_wdata = wb inputs.
  - else !empty -> FIFO head.
  - else 5'd0 / 32'd0.
- Writeback to x0 does not occupy the port; the FIFO head may drain in that cycle.
- Head entries with waddr 0 are popped with no write (o_rd_waddr = 0).
- o_ld_ready = !full. It does not depend on a same-cycle pop: a full FIFO is not ready even when popping.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- A beat pushed into an empty FIFO is not visible until the next cycle (no flow-through). Minimum accept-to-RF-write latency is 1 cycle.
- Pointers wrap modulo DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- o_ld_pending is the OR of the one-hot decode of waddr over valid entries, with bit 0 masked.
  - A bit clears in the cycle after the last matching entry pops.
  - Multiple entries to the same register are allowed; the bit stays set until all have drained.
- Starvation counter:
  - Increments when !empty & wb_act.
  - Clears on any pop or when the FIFO is empty.
  - On a blocked cycle with counter == STARVE_MAX-1: o_wb_stall is set for exactly the next cycle and the counter clears.
  - o_wb_stall is never asserted two consecutive cycles.
- Pipeline contract: i_wb_valid = 0 whenever o_wb_stall = 1.
  - If violated, writeback still wins the port (data is never lost).
  - o_collision = o_wb_stall & i_wb_valid, combinational.
- Reset (async assert, sync-safe deassert): FIFO empty, pointers 0, counter 0, o_wb_stall 0, o_ld_pending 0.
  - Outputs during reset: o_rd_waddr 0 unless wb_act, o_ld_ready 1.
  - Pushes while i_rst_n = 0 are discarded. Buffered entries are lost on reset mid-operation; the cache flushes its miss state on the same reset.

Decomposition:
- Shared package: RF_AW = 5, XLEN = 32, REG_ZERO = 5'd0.
- One natural sub-module: ld_fifo (sync FIFO, DEPTH x (5+32), push/pop/full/empty, head output, entry-valid vector + waddr array for the mask).
- Arbitration, starvation counter and mask decode stay in the top.

Test Plan:
- Lone load: i_ld_valid with x5 = 32'hDEADBEEF, no wb.
  - Next cycle: o_rd_waddr = 5, o_rd_wdata = DEADBEEF.
  - o_ld_pending[5] is 1 for one cycle, then 0.
- Priority: wb x3 = 1 and load x7 = 2 queued in the same cycle.
  - Cycle 1: RF gets x3 = 1.
  - Cycle 2: RF gets x7 = 2.
  - o_ld_pending[7] holds until cycle 2.
- Full/backpressure (DEPTH = 2): push x1, x2 while wb is continuously active.
  - o_ld_ready = 0 after 2 beats; a third beat x4 is held and not accepted.
  - Releasing wb drains in order x1, x2, x4.
- Starvation (STARVE_MAX = 4): queue 1 load and hold wb_act.
  - o_wb_stall = 1 in the cycle after the 4th blocked cycle.
  - Bench drops i_wb_valid; the load writes in that cycle; o_collision stays 0.
- Writeback to x0 plus queued load x9: the load drains in the same cycle. A load to x0 pops with o_rd_waddr = 0 and no pending bit set.
- Async reset with 2 entries queued mid-stream:
  - Outputs go empty/idle immediately, o_ld_pending = 0, o_wb_stall = 0.
  - After release, a fresh load to x6 writes with latency 1.

Source files
------------

// File: rtl/rf_wb_arb_pkg.sv
// Shared widths and helpers for the register-file write-port arbiter.
package rf_wb_arb_pkg;

    localparam int RF_AW = 5;
    localparam int XLEN  = 32;
    localparam logic [RF_AW-1:0] REG_ZERO = 5'd0;

    // One buffered load-return beat.
    typedef struct packed {
        logic [RF_AW-1:0] waddr;
        logic [XLEN-1:0]  wdata;
    } ld_beat_t;

    // One-hot decode of a register index; x0 never reports as pending.
    function automatic logic [XLEN-1:0] reg_onehot(input logic [RF_AW-1:0] r);
        logic [XLEN-1:0] v;
        v = '0;
        if (r != REG_ZERO) v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rf_wb_arb_ld_fifo.sv
// Synchronous load-return FIFO; exposes per-entry valid bits and
// destinations so the top can build the pending-register mask.
module ld_fifo
    import rf_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  ld_beat_t             din,
    output ld_beat_t             head,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH-1:0]     ent_valid,
    output logic [RF_AW-1:0]     ent_waddr [DEPTH]
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ld_beat_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Destination view of the storage for the pending mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_waddr[i] = mem[i].waddr;
    end

    // Storage is data-only; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            if (push) begin
                wr_ptr            <= wr_ptr + 1'b1;
                ent_valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr            <= rd_ptr + 1'b1;
                ent_valid[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority,
// load returns are buffered and drain whenever the port is free.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wb_valid,
    input  logic [RF_AW-1:0] i_wb_waddr,
    input  logic [XLEN-1:0]  i_wb_wdata,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [RF_AW-1:0] i_ld_waddr,
    input  logic [XLEN-1:0]  i_ld_wdata,
    output logic [RF_AW-1:0] o_rd_waddr,
    output logic [XLEN-1:0]  o_rd_wdata,
    output logic [XLEN-1:0]  o_ld_pending,
    output logic             o_wb_stall,
    output logic             o_collision
);

    localparam int SW = $clog2(STARVE_MAX) + 1;

    logic             wb_act;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic             blocked;
    ld_beat_t         head;
    ld_beat_t         din;
    logic [DEPTH-1:0] ent_valid;
    logic [RF_AW-1:0] ent_waddr [DEPTH];
    logic [SW-1:0]    starve_cnt;

    assign wb_act      = i_wb_valid && (i_wb_waddr != REG_ZERO);
    assign o_ld_ready  = !full;
    assign push        = i_ld_valid && o_ld_ready;
    assign pop         = !empty && !wb_act;
    assign blocked     = !empty && wb_act;
    assign din         = '{waddr: i_ld_waddr, wdata: i_ld_wdata};
    assign o_collision = o_wb_stall && i_wb_valid;

    ld_fifo #(.DEPTH(DEPTH)) u_ld_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_waddr (ent_waddr)
    );

    // Write-port mux: writeback first, then FIFO head (x0 heads write nothing).
    always_comb begin
        o_rd_waddr = REG_ZERO;
        o_rd_wdata = '0;
        if (wb_act) begin
            o_rd_waddr = i_wb_waddr;
            o_rd_wdata = i_wb_wdata;
        end else if (!empty) begin
            o_rd_waddr = head.waddr;
            o_rd_wdata = head.wdata;
        end
    end

    // Pending mask: OR of destinations over valid entries, x0 excluded.
    always_comb begin
        o_ld_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) o_ld_pending = o_ld_pending | reg_onehot(ent_waddr[i]);
        end
    end

    // Starvation counter; the stall request is one cycle wide and never
    // back-to-back even if the pipeline ignores it (matters for STARVE_MAX=1).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt <= '0;
            o_wb_stall <= 1'b0;
        end else begin
            o_wb_stall <= 1'b0;
            if (!blocked) begin
                starve_cnt <= '0;
            end else if (starve_cnt == SW'(STARVE_MAX - 1)) begin
                starve_cnt <= '0;
                o_wb_stall <= !o_wb_stall;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule
